foreground_fetch: RTL and testbench

- Sits directly upstream of the pipeline's foreground input and serves its foreground pixel requests from the external foreground SRAM frame buffer.
- Returns each response exactly FOREGROUND_FETCH_CYCLE_DELAY cycles after the request. Out-of-frame requests are answered as skips.
- Also accepts foreground frame writes from the capture side through a small FIFO. Writes drain into SRAM only in cycles not used by a read.

---
 rtl/foreground_fetch_pkg.sv | 28 ++
 rtl/foreground_fetch_write_fifo.sv | 61 ++++++
 rtl/foreground_fetch.sv | 133 +++++++++++++
 tb/tb_foreground_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/foreground_fetch_pkg.sv
// Shared foreground frame constants, write-entry layout and the xy-to-address mapping
// used by the fetch block and the pipeline.
package foreground_fetch_pkg;

   localparam int PIXEL_SIZE = 16;
   localparam int PRECISION  = 11;
   localparam int FG_WIDTH   = 800;
   localparam int FG_HEIGHT  = 600;
   localparam int ADDR_WIDTH = 19;

   typedef struct packed {
      logic active;
      logic skip;
   } fetch_tag_t;

   typedef struct packed {
      logic [PRECISION-1:0]  x;
      logic [PRECISION-1:0]  y;
      logic [PIXEL_SIZE-1:0] pixel;
   } fg_write_t;

   // Row-major frame address, truncated to the SRAM address width.
   function automatic logic [ADDR_WIDTH-1:0] xy_to_addr(input logic [PRECISION-1:0] x,
                                                         input logic [PRECISION-1:0] y);
      return ADDR_WIDTH'(32'(y) * FG_WIDTH + 32'(x));
   endfunction

endpackage

// File: rtl/foreground_fetch_write_fifo.sv
// Synchronous write FIFO with registered ready (not full), empty and occupancy count.
module fg_write_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 38
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             ready,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      push_ok    = push & ready;
      pop_ok     = pop & !empty;
      count_next = count;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // ready is held low through reset and rises on the first clock after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         ready <= (count_next < CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/foreground_fetch.sv
// Foreground pixel fetch: fixed-latency SRAM reads with out-of-frame skips, plus a
// capture-side write FIFO that drains into SRAM on cycles without a read.
module foreground_fetch
   import foreground_fetch_pkg::*;
#(
   parameter int SRAM_READ_LATENCY            = 1,
   parameter int FOREGROUND_FETCH_CYCLE_DELAY = 3,
   parameter int WR_FIFO_DEPTH                = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [PRECISION:0]    fg_pixel_request_x,
   input  logic signed [PRECISION:0]    fg_pixel_request_y,
   input  logic                         fg_pixel_request_active,
   output logic [PIXEL_SIZE-1:0]        fg_pixel_out,
   output logic                         fg_pixel_skip,
   output logic                         fg_pixel_ready,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [PRECISION-1:0]         wr_x,
   input  logic [PRECISION-1:0]         wr_y,
   input  logic [PIXEL_SIZE-1:0]        wr_pixel,
   output logic [ADDR_WIDTH-1:0]        sram_addr,
   output logic                         sram_re,
   output logic                         sram_we,
   output logic [PIXEL_SIZE-1:0]        sram_wdata,
   input  logic [PIXEL_SIZE-1:0]        sram_rdata
);

   localparam int TAG_LEN  = FOREGROUND_FETCH_CYCLE_DELAY - 1;
   localparam int DATA_DLY = FOREGROUND_FETCH_CYCLE_DELAY - 2 - SRAM_READ_LATENCY;

   if (FOREGROUND_FETCH_CYCLE_DELAY < SRAM_READ_LATENCY + 2) begin : g_bad_delay
      $error("FOREGROUND_FETCH_CYCLE_DELAY must be >= SRAM_READ_LATENCY+2");
   end

   logic                  in_range;
   logic                  rd_next;
   logic [ADDR_WIDTH-1:0] req_addr;
   fg_write_t             head;
   logic                  fifo_empty;
   logic                  pop;
   logic                  head_ok;
   logic [ADDR_WIDTH-1:0] wr_addr;
   fetch_tag_t            tag_q [TAG_LEN];
   logic [PIXEL_SIZE-1:0] resp_data;

   // A negative coordinate has its sign bit set, so checking it first makes the
   // unsigned magnitude compares equivalent to a signed range check.
   always_comb begin
      in_range = !fg_pixel_request_x[PRECISION] && !fg_pixel_request_y[PRECISION]
                 && (32'(fg_pixel_request_x[PRECISION-1:0]) < FG_WIDTH)
                 && (32'(fg_pixel_request_y[PRECISION-1:0]) < FG_HEIGHT);
      req_addr = xy_to_addr(fg_pixel_request_x[PRECISION-1:0],
                            fg_pixel_request_y[PRECISION-1:0]);
      rd_next  = fg_pixel_request_active & in_range;
      pop      = !rd_next & !fifo_empty;
      head_ok  = (32'(head.x) < FG_WIDTH) && (32'(head.y) < FG_HEIGHT);
      wr_addr  = xy_to_addr(head.x, head.y);
   end

   // Write handshake: an entry is accepted on a clock edge where wr_valid and wr_ready
   // are both high; wr_valid may rise at any time and wr_ready never depends on it.
   fg_write_fifo #(
      .DEPTH (WR_FIFO_DEPTH),
      .WIDTH ($bits(fg_write_t))
   ) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid),
      .push_data ({wr_x, wr_y, wr_pixel}),
      .pop       (pop),
      .head_data (head),
      .ready     (wr_ready),
      .empty     (fifo_empty)
   );

   // Reads always own the port; out-of-frame writes are popped with no strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_re    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_re    <= rd_next;
         sram_we    <= pop & head_ok;
         sram_wdata <= (pop & head_ok) ? head.pixel : '0;
         if (rd_next)             sram_addr <= req_addr;
         else if (pop & head_ok)  sram_addr <= wr_addr;
         else                     sram_addr <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAG_LEN; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{active: fg_pixel_request_active,
                       skip:   fg_pixel_request_active & !in_range};
         for (int i = 1; i < TAG_LEN; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Extra data stages only exist when the response delay exceeds the read path.
   if (DATA_DLY == 0) begin : g_no_data_dly
      assign resp_data = sram_rdata;
   end else begin : g_data_dly
      logic [PIXEL_SIZE-1:0] data_q [DATA_DLY];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DATA_DLY; i++) data_q[i] <= '0;
         end else begin
            data_q[0] <= sram_rdata;
            for (int i = 1; i < DATA_DLY; i++) data_q[i] <= data_q[i-1];
         end
      end
      assign resp_data = data_q[DATA_DLY-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fg_pixel_ready <= 1'b0;
         fg_pixel_skip  <= 1'b0;
         fg_pixel_out   <= '0;
      end else begin
         fg_pixel_ready <= tag_q[TAG_LEN-1].active;
         fg_pixel_skip  <= tag_q[TAG_LEN-1].active & tag_q[TAG_LEN-1].skip;
         fg_pixel_out   <= (tag_q[TAG_LEN-1].active & !tag_q[TAG_LEN-1].skip) ? resp_data : '0;
      end
   end

endmodule

// File: tb/tb_foreground_fetch.sv
// Directed bench for foreground_fetch with a behavioural one-cycle-latency SRAM.
module tb_foreground_fetch;
   import foreground_fetch_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst;
   logic signed [PRECISION:0] req_x;
   logic signed [PRECISION:0] req_y;
   logic                      req_active;
   logic [PIXEL_SIZE-1:0]     fg_pixel_out;
   logic                      fg_pixel_skip;
   logic                      fg_pixel_ready;
   logic                      wr_valid;
   logic                      wr_ready;
   logic [PRECISION-1:0]      wr_x;
   logic [PRECISION-1:0]      wr_y;
   logic [PIXEL_SIZE-1:0]     wr_pixel;
   logic [ADDR_WIDTH-1:0]     sram_addr;
   logic                      sram_re;
   logic                      sram_we;
   logic [PIXEL_SIZE-1:0]     sram_wdata;
   logic [PIXEL_SIZE-1:0]     sram_rdata = '0;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int re_count = 0;
   int conflict_count = 0;
   int ready_pulses = 0;

   logic [PIXEL_SIZE-1:0] sram_mem [int];
   logic [ADDR_WIDTH-1:0] we_addr_q [$];
   logic [PIXEL_SIZE-1:0] we_data_q [$];
   int                    we_cyc_q  [$];

   foreground_fetch dut (
      .clk                     (clk),
      .rst                     (rst),
      .fg_pixel_request_x      (req_x),
      .fg_pixel_request_y      (req_y),
      .fg_pixel_request_active (req_active),
      .fg_pixel_out            (fg_pixel_out),
      .fg_pixel_skip           (fg_pixel_skip),
      .fg_pixel_ready          (fg_pixel_ready),
      .wr_valid                (wr_valid),
      .wr_ready                (wr_ready),
      .wr_x                    (wr_x),
      .wr_y                    (wr_y),
      .wr_pixel                (wr_pixel),
      .sram_addr               (sram_addr),
      .sram_re                 (sram_re),
      .sram_we                 (sram_we),
      .sram_wdata              (sram_wdata),
      .sram_rdata              (sram_rdata)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // SRAM model and port monitor
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (sram_we) begin
         sram_mem[int'(sram_addr)] = sram_wdata;
         we_addr_q.push_back(sram_addr);
         we_data_q.push_back(sram_wdata);
         we_cyc_q.push_back(cycle);
      end
      if (sram_re) begin
         re_count++;
         sram_rdata <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : '0;
      end
      if (sram_re && sram_we) conflict_count++;
   end

   always @(negedge clk) begin
      if (fg_pixel_ready === 1'b1) ready_pulses++;
   end

   // driver tasks
   task automatic drive_idle();
      req_active = 1'b0;
      req_x      = '0;
      req_y      = '0;
      wr_valid   = 1'b0;
      wr_x       = '0;
      wr_y       = '0;
      wr_pixel   = '0;
   endtask

   task automatic drive_read(input logic signed [PRECISION:0] x, input logic signed [PRECISION:0] y);
      req_active = 1'b1;
      req_x      = x;
      req_y      = y;
   endtask

   task automatic drive_write(input logic [PRECISION-1:0] x, input logic [PRECISION-1:0] y,
                              input logic [PIXEL_SIZE-1:0] p);
      wr_valid = 1'b1;
      wr_x     = x;
      wr_y     = y;
      wr_pixel = p;
   endtask

   task automatic clear_log();
      we_addr_q.delete();
      we_data_q.delete();
      we_cyc_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++; if (fg_pixel_ready !== 1'b0) begin errors++; $display("FAIL %s_ready: got %0b want 0", tag, fg_pixel_ready); end
      checks++; if (fg_pixel_skip !== 1'b0) begin errors++; $display("FAIL %s_skip: got %0b want 0", tag, fg_pixel_skip); end
      checks++; if (fg_pixel_out !== '0) begin errors++; $display("FAIL %s_out: got %0h want 0", tag, fg_pixel_out); end
      checks++; if (sram_re !== 1'b0) begin errors++; $display("FAIL %s_re: got %0b want 0", tag, sram_re); end
      checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL %s_we: got %0b want 0", tag, sram_we); end
      checks++; if (sram_addr !== '0) begin errors++; $display("FAIL %s_addr: got %0d want 0", tag, sram_addr); end
      checks++; if (sram_wdata !== '0) begin errors++; $display("FAIL %s_wdata: got %0h want 0", tag, sram_wdata); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL %s_wr_ready: got %0b want 0", tag, wr_ready); end
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("rst");
      rst = 1'b0;
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_wr_ready: got %0b want 1", wr_ready); end
   endtask

   task automatic test_read_basic();
      sram_mem[0]   = 16'hF800;
      sram_mem[801] = 16'h07E0;
      drive_read(0, 0);
      @(negedge clk);
      checks++; if (sram_re !== 1'b1 || sram_addr !== 19'd0) begin errors++; $display("FAIL rd0_issue: got re=%0b addr=%0d want re=1 addr=0", sram_re, sram_addr); end
      drive_read(1, 1);
      @(negedge clk);
      checks++; if (sram_re !== 1'b1 || sram_addr !== 19'd801) begin errors++; $display("FAIL rd1_issue: got re=%0b addr=%0d want re=1 addr=801", sram_re, sram_addr); end
      drive_idle();
      @(negedge clk);
      checks++; if (fg_pixel_ready !== 1'b1 || fg_pixel_skip !== 1'b0 || fg_pixel_out !== 16'hF800) begin
         errors++; $display("FAIL rd0_resp: got ready=%0b skip=%0b out=%0h want 1 0 f800", fg_pixel_ready, fg_pixel_skip, fg_pixel_out); end
      @(negedge clk);
      checks++; if (fg_pixel_ready !== 1'b1 || fg_pixel_skip !== 1'b0 || fg_pixel_out !== 16'h07E0) begin
         errors++; $display("FAIL rd1_resp: got ready=%0b skip=%0b out=%0h want 1 0 7e0", fg_pixel_ready, fg_pixel_skip, fg_pixel_out); end
      @(negedge clk);
      checks++; if (fg_pixel_ready !== 1'b0 || fg_pixel_out !== '0) begin
         errors++; $display("FAIL rd_idle_resp: got ready=%0b out=%0h want 0 0", fg_pixel_ready, fg_pixel_out); end
   endtask

   task automatic test_skip();
      logic signed [PRECISION:0] sx [3];
      logic signed [PRECISION:0] sy [3];
      int re_base;
      sx[0] = -1;  sy[0] = 5;
      sx[1] = 800; sy[1] = 0;
      sx[2] = 0;   sy[2] = 600;
      re_base = re_count;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive_read(sx[i], sy[i]);
         else       drive_idle();
         @(negedge clk);
         if (i >= 2) begin
            checks++; if (fg_pixel_ready !== 1'b1 || fg_pixel_skip !== 1'b1 || fg_pixel_out !== '0) begin
               errors++; $display("FAIL skip_resp%0d: got ready=%0b skip=%0b out=%0h want 1 1 0", i - 2, fg_pixel_ready, fg_pixel_skip, fg_pixel_out); end
         end
      end
      @(negedge clk);
      checks++; if (re_count !== re_base) begin errors++; $display("FAIL skip_no_re: got %0d reads want 0", re_count - re_base); end
   endtask

   task automatic test_back_to_back();
      int k;
      int pulse_base;
      clear_log();
      pulse_base = ready_pulses;
      for (int i = 0; i < 10; i++) begin
         drive_read(i, 0);
         if (i < 4) drive_write(11'(20 + i), 11'd3, 16'hA000 + 16'(i));
         else       wr_valid = 1'b0;
         @(negedge clk);
         if (i == 3) begin
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_wr_ready_full: got %0b want 0", wr_ready); end
         end
      end
      drive_idle();
      checks++; if (we_addr_q.size() != 0) begin errors++; $display("FAIL b2b_we_during_reads: got %0d writes want 0", we_addr_q.size()); end
      k = 0;
      while (k < 20 && we_addr_q.size() < 4) begin
         @(negedge clk);
         k++;
      end
      checks++; if (we_addr_q.size() != 4) begin
         errors++; $display("FAIL b2b_drain_count: got %0d want 4", we_addr_q.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            checks++; if (we_addr_q[j] !== 19'(2420 + j) || we_data_q[j] !== 16'hA000 + 16'(j) || we_cyc_q[j] != we_cyc_q[0] + j) begin
               errors++; $display("FAIL b2b_drain%0d: got addr=%0d data=%0h cyc=+%0d want addr=%0d data=%0h cyc=+%0d",
                                  j, we_addr_q[j], we_data_q[j], we_cyc_q[j] - we_cyc_q[0], 2420 + j, 16'hA000 + 16'(j), j);
            end
         end
      end
      repeat (4) @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready_after: got %0b want 1", wr_ready); end
      checks++; if (ready_pulses - pulse_base != 10) begin errors++; $display("FAIL b2b_ready_pulses: got %0d want 10", ready_pulses - pulse_base); end
   endtask

   task automatic test_write_then_read();
      int k;
      clear_log();
      drive_write(11'd10, 11'd2, 16'h001F);
      @(negedge clk);
      drive_idle();
      k = 0;
      while (k < 10 && we_addr_q.size() < 1) begin
         @(negedge clk);
         k++;
      end
      checks++; if (we_addr_q.size() != 1 || we_addr_q[0] !== 19'd1610 || we_data_q[0] !== 16'h001F) begin
         errors++; $display("FAIL wr_then_rd_write: got n=%0d addr=%0d data=%0h want n=1 addr=1610 data=1f",
                            we_addr_q.size(), (we_addr_q.size() > 0) ? we_addr_q[0] : '0, (we_data_q.size() > 0) ? we_data_q[0] : '0);
      end
      drive_read(10, 2);
      @(negedge clk);
      checks++; if (sram_re !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 19'd1610) begin
         errors++; $display("FAIL wr_then_rd_issue: got re=%0b we=%0b addr=%0d want 1 0 1610", sram_re, sram_we, sram_addr); end
      drive_idle();
      repeat (2) @(negedge clk);
      checks++; if (fg_pixel_ready !== 1'b1 || fg_pixel_skip !== 1'b0 || fg_pixel_out !== 16'h001F) begin
         errors++; $display("FAIL wr_then_rd_resp: got ready=%0b skip=%0b out=%0h want 1 0 1f", fg_pixel_ready, fg_pixel_skip, fg_pixel_out); end
   endtask

   task automatic test_reset_inflight();
      int pulse_base;
      clear_log();
      drive_read(0, 0);
      drive_write(11'd5, 11'd5, 16'h1234);
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_inflight");
      pulse_base = ready_pulses;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (ready_pulses != pulse_base) begin errors++; $display("FAIL rst_inflight_ready: got %0d pulses want 0", ready_pulses - pulse_base); end
      checks++; if (we_addr_q.size() != 0) begin errors++; $display("FAIL rst_inflight_fifo: got %0d writes want 0", we_addr_q.size()); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_inflight_wr_ready: got %0b want 1", wr_ready); end
   endtask

   task automatic test_oob_write();
      clear_log();
      drive_write(11'd900, 11'd10, 16'hBEEF);
      @(negedge clk);
      drive_idle();
      checks++; if (dut.u_wr_fifo.count != 1) begin errors++; $display("FAIL oob_count_push: got %0d want 1", dut.u_wr_fifo.count); end
      @(negedge clk);
      checks++; if (dut.u_wr_fifo.count != 0) begin errors++; $display("FAIL oob_count_pop: got %0d want 0", dut.u_wr_fifo.count); end
      checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL oob_we: got %0b want 0", sram_we); end
      repeat (3) @(negedge clk);
      checks++; if (we_addr_q.size() != 0) begin errors++; $display("FAIL oob_no_write: got %0d writes want 0", we_addr_q.size()); end
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;
      test_reset();
      test_read_basic();
      test_skip();
      test_back_to_back();
      test_write_then_read();
      test_reset_inflight();
      test_oob_write();
      checks++; if (conflict_count != 0) begin errors++; $display("FAIL port_conflict: got %0d want 0", conflict_count); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
